rx_fifo: RTL and testbench
==========================

# rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It takes each completed byte from the receiver's `data`/`dataready` outputs and acknowledges it with a `readdata` pulse. It tags each byte with its framing status, clears the receiver's sticky error flags, and presents the bytes to the host logic through a show-ahead FIFO with overflow accounting.

## Interface
- `DEPTH`, 16: number of FIFO entries; a power of two, at least 2.
- `AW`, 4: address width; must equal log2(`DEPTH`).

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  byte from the receiver.
- `rx_dataready`  in  1  receiver has a byte; stays high until acknowledged.
- `rx_framing`  in  1  receiver's sticky framing-error flag.
- `rx_overrun`  in  1  receiver's sticky overrun flag.
- `rx_readdata`  out  1  acknowledge to the receiver; one-cycle pulse.
- `rx_clearerr`  out  1  clears the receiver's error flags; one-cycle pulse.
- `pop`  in  1  consumer takes `dout`.
- `dout`  out  8  head entry data; show-ahead.
- `dout_ferr`  out  1  framing flag of the head entry.
- `valid`  out  1  FIFO not empty.
- `full`  out  1  count equals `DEPTH`.
- `count`  out  AW+1  number of stored entries, 0..`DEPTH`.
- `ovf`  out  1  sticky error: byte dropped or receiver overrun seen.
- `ovf_clear`  in  1  clears `ovf` and `dropcount`.
- `dropcount`  out  8  bytes dropped because the FIFO was full; saturates at 255.

## Operation
- Storage is `DEPTH` x 9 bits, each entry holding {framing, data}.
- `wptr` and `rptr` are AW bits wide and wrap modulo `DEPTH`.
- `count` is a separate AW+1-bit register.
- Capture FSM has three states: IDLE, ACK, DRAIN.
- IDLE, when `rx_dataready`=1:
  - If not `full`: write {`rx_framing`, `rx_data`} at `wptr`, then `wptr`+1.
  - If `full`: the byte is discarded, `ovf` is set, and `dropcount` increments unless it is already 255.
  - If `rx_overrun`=1: set `ovf`.
  - Go to ACK.
- ACK:
  - `rx_readdata`=1 for exactly this cycle.
  - `rx_clearerr`=1 in the same cycle if `rx_framing` or `rx_overrun` was high at capture.
  - Go to DRAIN.
- DRAIN: stay until `rx_dataready`=0, then go to IDLE. This prevents a second capture of the same byte.
- `rx_readdata` and `rx_clearerr` are registered outputs, decoded from state and captured flags, with no combinational path from inputs.
- Read side:
  - `dout` and `dout_ferr` always reflect the entry at `rptr`.
  - `pop`=1 with `valid`=1 advances `rptr` and decrements `count`.
  - `pop` while empty is ignored.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged.
- Push attempt while `full`, with `pop` in the same cycle: the byte is dropped, because `full` is evaluated from the registered count. The pop still proceeds.
- `ovf_clear` in the same cycle as a new drop or overrun: the set wins, and `dropcount` becomes 1.
- Default or illegal FSM state: go to IDLE with no write.

## Timing
- Reset (asynchronous) forces:
  - State to IDLE.
  - `wptr`, `rptr`, `count` to 0.
  - `rx_readdata`, `rx_clearerr`, `ovf` to 0, and `dropcount` to 0.
  - `valid`=0 and `full`=0.
- Memory contents are not reset. `dout` is don't-care while `valid`=0.
- Reset mid-handshake abandons the byte. After reset the FSM is in IDLE and may recapture if `rx_dataready` is still high.
- Capture latency, with `rx_dataready` first high in cycle N:
  - Entry written at the end of N; `valid`/`count` update in N+1.
  - `rx_readdata` is high in N+1.
  - The receiver drops `rx_dataready` at the end of N+1.
  - FSM returns to IDLE at the end of N+2.
- The earliest next capture is cycle N+3, which fits inside one byte time at any supported baud rate.
- Pop latency: a pop in cycle M shows the new head in M+1.
- Full to not-full takes one cycle after a pop.

## Test plan
- Single byte: receiver presents 0x5A, framing=0.
  - Expected: `valid`=1 with `dout`=0x5A and `dout_ferr`=0 one cycle later.
  - Expected: exactly one `rx_readdata` pulse and no `rx_clearerr`.
- Framing tag: byte 0xC3 with `rx_framing`=1.
  - Expected: entry read back as 0xC3 with `dout_ferr`=1.
  - Expected: `rx_clearerr` pulses together with `rx_readdata`.
  - Expected: the next byte, 0x11, has `dout_ferr`=0.
- Fill and overflow: push 16 bytes 0x00..0x0F with no pops, then push 0xAA.
  - Expected: `full`=1 and `count`=16; the 17th byte is acknowledged but dropped.
  - Expected: `ovf`=1, `dropcount`=1, and the pops return 0x00..0x0F in order.
- Wrap with simultaneous push/pop: keep `count`=3 and push/pop together for 40 cycles.
  - Expected: `count` stays 3, data stays in order across pointer wrap, and no drops.
- Pop while empty: `pop`=1 with `count`=0.
  - Expected: `count` stays 0 and the pointers are unchanged.
  - Expected: the next byte 0x7E appears at `dout`.
- Async reset mid-ACK: assert `reset` while `rx_readdata`=1.
  - Expected: all outputs go to 0 immediately with no clock edge, and `count`=0.
  - Expected: after release, the FSM recaptures if `rx_dataready` is still high.

Source files
------------

// File: rtl/rx_fifo.sv
// Receive-side buffer for the UART receiver: handshakes each byte, tags it with its framing
// status, and presents it to the host through a show-ahead FIFO with overflow accounting.
module rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_dataready,
    input  logic          rx_framing,
    input  logic          rx_overrun,
    output logic          rx_readdata,
    output logic          rx_clearerr,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          dout_ferr,
    output logic          valid,
    output logic          full,
    output logic [AW:0]   count,
    output logic          ovf,
    input  logic          ovf_clear,
    output logic [7:0]    dropcount
);

    localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CntOne   = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne   = AW'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAck   = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          readdata_q, readdata_d;
    logic          clearerr_q, clearerr_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    dropcount_q, dropcount_d;

    logic capture;
    logic push_en;
    logic drop;
    logic pop_en;
    logic ovf_set;
    logic full_int;
    logic valid_int;
    logic [8:0] head;

    assign full_int  = (count_q == DepthCnt);
    assign valid_int = (count_q != '0);

    // Capture FSM: one capture per byte, then wait for the receiver to drop dataready.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_dataready) begin
                    capture = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StDrain;
            end
            StDrain: begin
                if (!rx_dataready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake outputs are registered so they are decoded from the state being entered.
    always_comb begin
        readdata_d = (state_d == StAck) && (state_q == StIdle);
        clearerr_d = readdata_d && (rx_framing || rx_overrun);
    end

    assign push_en = capture && !full_int;
    assign drop    = capture && full_int;
    assign ovf_set = drop || (capture && rx_overrun);
    assign pop_en  = pop && valid_int;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_en) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (pop_en) begin
            rptr_d = rptr_q + PtrOne;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // A new drop or overrun in the same cycle as a clear wins over the clear.
    always_comb begin
        ovf_d       = ovf_q;
        dropcount_d = dropcount_q;
        if (ovf_clear) begin
            ovf_d       = 1'b0;
            dropcount_d = '0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        if (drop) begin
            if (ovf_clear) begin
                dropcount_d = 8'd1;
            end else if (dropcount_q != 8'hFF) begin
                dropcount_d = dropcount_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            readdata_q  <= 1'b0;
            clearerr_q  <= 1'b0;
            ovf_q       <= 1'b0;
            dropcount_q <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            readdata_q  <= readdata_d;
            clearerr_q  <= clearerr_d;
            ovf_q       <= ovf_d;
            dropcount_q <= dropcount_d;
        end
    end

    // Storage is deliberately not reset; the head is only meaningful while valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wptr_q] <= {rx_framing, rx_data};
        end
    end

    assign head        = mem[rptr_q];
    assign dout        = head[7:0];
    assign dout_ferr   = head[8];
    assign valid       = valid_int;
    assign full        = full_int;
    assign count       = count_q;
    assign rx_readdata = readdata_q;
    assign rx_clearerr = clearerr_q;
    assign ovf         = ovf_q;
    assign dropcount   = dropcount_q;

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: directed and random receiver traffic compared against
// a queue-based reference model of the FIFO and its overflow accounting.
module tb_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_dataready;
    logic          rx_framing;
    logic          rx_overrun;
    logic          rx_readdata;
    logic          rx_clearerr;
    logic          pop;
    logic [7:0]    dout;
    logic          dout_ferr;
    logic          valid;
    logic          full;
    logic [AW:0]   count;
    logic          ovf;
    logic          ovf_clear;
    logic [7:0]    dropcount;

    rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_dataready (rx_dataready),
        .rx_framing   (rx_framing),
        .rx_overrun   (rx_overrun),
        .rx_readdata  (rx_readdata),
        .rx_clearerr  (rx_clearerr),
        .pop          (pop),
        .dout         (dout),
        .dout_ferr    (dout_ferr),
        .valid        (valid),
        .full         (full),
        .count        (count),
        .ovf          (ovf),
        .ovf_clear    (ovf_clear),
        .dropcount    (dropcount)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [8:0] mq[$];
    bit         m_ovf;
    int         m_drop;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), mq.size());
        chk("valid", 32'(valid), 32'(mq.size() != 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("dropcount", 32'(dropcount), m_drop);
        if (mq.size() > 0) begin
            chk("dout", 32'(dout), 32'(mq[0][7:0]));
            chk("dout_ferr", 32'(dout_ferr), 32'(mq[0][8]));
        end
    endtask

    // One full receiver handshake; starts and ends 1 time unit after a rising edge.
    task automatic send(input logic [7:0] d, input logic fe, input logic ov,
                        input logic p, input logic clr);
        int n;
        chk("readdata_idle", 32'(rx_readdata), 0);
        rx_data      = d;
        rx_framing   = fe;
        rx_overrun   = ov;
        rx_dataready = 1'b1;
        pop          = p;
        ovf_clear    = clr;
        n = mq.size();
        if (p && n > 0) void'(mq.pop_front());
        if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        if (n == DEPTH) begin
            m_ovf  = 1'b1;
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end else begin
            mq.push_back({fe, d});
        end
        if (ov) m_ovf = 1'b1;
        @(posedge clk); #1;
        pop       = 1'b0;
        ovf_clear = 1'b0;
        chk("readdata_pulse", 32'(rx_readdata), 1);
        chk("clearerr_pulse", 32'(rx_clearerr), 32'(fe | ov));
        check_all();
        @(posedge clk); #1;
        rx_dataready = 1'b0;
        rx_framing   = 1'b0;
        rx_overrun   = 1'b0;
        chk("readdata_drain", 32'(rx_readdata), 0);
        chk("clearerr_drain", 32'(rx_clearerr), 0);
        @(posedge clk); #1;
    endtask

    task automatic pop_step(input logic p);
        pop = p;
        if (p && mq.size() > 0) void'(mq.pop_front());
        @(posedge clk); #1;
        pop = 1'b0;
        check_all();
    endtask

    task automatic clr_step();
        ovf_clear = 1'b1;
        m_ovf     = 1'b0;
        m_drop    = 0;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) pop_step(1'b1);
        chk("drained", 32'(count), 0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        m_ovf        = 1'b0;
        m_drop       = 0;
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_dataready = 1'b0;
        rx_framing   = 1'b0;
        rx_overrun   = 1'b0;
        pop          = 1'b0;
        ovf_clear    = 1'b0;
        #1;
        chk("rst_readdata", 32'(rx_readdata), 0);
        chk("rst_clearerr", 32'(rx_clearerr), 0);
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_all();

        // Single byte
        send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_step(1'b1);

        // Framing tag followed by a clean byte
        send(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_step(1'b1);
        pop_step(1'b1);

        // Pop while empty, then a byte must still land at the head
        pop_step(1'b1);
        pop_step(1'b1);
        send(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("dout_after_empty_pop", 32'(dout), 32'h7E);
        pop_step(1'b1);

        // Fill and overflow
        for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 1);
        send(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_after_drop", 32'(ovf), 1);
        chk("drop_after_drop", 32'(dropcount), 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_order", 32'(dout), i);
            pop_step(1'b1);
        end
        clr_step();

        // Overrun alone sets ovf and requests a clear
        send(8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_step(1'b1);
        clr_step();

        // Wrap with simultaneous push/pop at count 3
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
            chk("wrap_count", 32'(count), 3);
        end
        chk("wrap_no_drop", 32'(dropcount), 0);
        drain();

        // Drop counter saturation, then clear racing a new drop
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 258; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_saturated", 32'(dropcount), 255);
        send(8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear_vs_drop", 32'(dropcount), 1);
        send(8'h98, 1'b0, 1'b0, 1'b1, 1'b0);
        clr_step();
        drain();

        // Random traffic
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: send(8'($urandom), 1'($urandom_range(0, 3) == 0),
                              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'b0);
                3, 4:    pop_step(1'b1);
                default: clr_step();
            endcase
        end

        // Async reset in the middle of the acknowledge cycle
        send(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        rx_data      = 8'h3C;
        rx_framing   = 1'b0;
        rx_overrun   = 1'b0;
        rx_dataready = 1'b1;
        @(posedge clk); #1;
        chk("mid_readdata", 32'(rx_readdata), 1);
        chk("mid_ovf", 32'(ovf), 1);
        #2 reset = 1'b1;
        #1;
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        chk("async_readdata", 32'(rx_readdata), 0);
        chk("async_clearerr", 32'(rx_clearerr), 0);
        check_all();
        #2 reset = 1'b0;
        mq.push_back({1'b0, 8'h3C});
        @(posedge clk); #1;
        chk("recapture_readdata", 32'(rx_readdata), 1);
        check_all();
        @(posedge clk); #1;
        rx_dataready = 1'b0;
        @(posedge clk); #1;
        chk("recapture_dout", 32'(dout), 32'h3C);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
